load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3.
- Runs a request/acknowledge transaction to data memory, generating byte enables and lane-replicated store data.
- Returns sign- or zero-extended load data to writeback with a done pulse.

---
 rtl/load_store_unit_pkg.sv | 46 ++++
 rtl/lsu_load_align.sv | 38 +++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants, types and helpers for the load/store unit.
package load_store_unit_pkg;

   localparam int unsigned LSU_WIDTH = 32;
   localparam int unsigned LSU_LANES = 4;
   localparam int unsigned LSU_OFF_W = 2;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_DONE = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_e;

   typedef struct packed {
      logic                 is_store;
      logic [2:0]           funct3;
      logic [LSU_OFF_W-1:0] off;
   } lsu_op_t;

   // Illegal encodings fall back to a full-word access.
   function automatic lsu_size_e f3_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         F3_W:        return SZ_W;
         default:     return SZ_W;
      endcase
   endfunction

   function automatic logic f3_illegal(input logic [2:0] f3);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane selection and sign/zero extension of the memory read word.
module lsu_load_align
   import load_store_unit_pkg::*;
(
   input  logic [LSU_OFF_W-1:0] i_off,
   input  logic [2:0]           i_funct3,
   input  logic [LSU_WIDTH-1:0] i_rdata,
   output logic [LSU_WIDTH-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_signed;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_off)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
   end

   // Halfword lane comes from off[1] only; off[0] is ignored for misaligned halves.
   assign w_half   = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
   assign w_signed = (i_funct3 == F3_B) || (i_funct3 == F3_H);

   always_comb begin
      o_data = i_rdata;
      case (f3_size(i_funct3))
         SZ_B:    o_data = {{24{w_signed & w_byte[7]}}, w_byte};
         SZ_H:    o_data = {{16{w_signed & w_half[15]}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: req/ack data-memory transaction with lane steering.
// Optional misalignment/illegal-size trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned WIDTH = LSU_WIDTH
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 is_store,
   input  logic [2:0]           funct3,
   input  logic [WIDTH-1:0]     addr,
   input  logic [WIDTH-1:0]     wdata,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     rdata,
   output logic                 fault,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [WIDTH-1:0]     mem_addr,
   output logic [LSU_LANES-1:0] mem_be,
   output logic [WIDTH-1:0]     mem_wdata,
   input  logic                 mem_ack,
   input  logic [WIDTH-1:0]     mem_rdata
);

   lsu_state_e           r_state, w_state_n;
   lsu_op_t              r_op;
   logic                 r_busy, r_done, r_mem_req, r_mem_we;
   logic [WIDTH-1:0]     r_rdata, r_mem_addr, r_mem_wdata;
   logic [LSU_LANES-1:0] r_mem_be;
   logic [LSU_LANES-1:0] w_be;
   logic [WIDTH-1:0]     w_wdata, w_load_data;
   logic                 w_accept, w_is_store_n, w_trap;

   assign w_accept     = (r_state == LSU_IDLE) && start;
   assign w_is_store_n = w_accept ? is_store : r_op.is_store;

`ifdef LSU_MISALIGN_TRAP_EN
   logic w_misalign;
   logic r_fault;
   always_comb begin
      w_misalign = f3_illegal(funct3);
      case (f3_size(funct3))
         SZ_H:    w_misalign = w_misalign | addr[0];
         SZ_W:    w_misalign = w_misalign | (addr[1:0] != 2'b00);
         default: w_misalign = w_misalign;
      endcase
   end
   assign w_trap = w_accept && w_misalign;
   assign fault  = r_fault;
`else
   assign w_trap = 1'b0;
   assign fault  = 1'b0;
`endif

   // Byte enables and lane-replicated store data from the incoming request.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = wdata;
      case (f3_size(funct3))
         SZ_B: begin
            w_be    = 4'(4'b0001 << addr[1:0]);
            w_wdata = {4{wdata[7:0]}};
         end
         SZ_H: begin
            w_be    = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = wdata;
         end
      endcase
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         LSU_IDLE: if (start) w_state_n = w_trap ? LSU_DONE : LSU_REQ;
         LSU_REQ:  if (mem_ack) w_state_n = LSU_DONE;
         LSU_DONE: w_state_n = LSU_IDLE;
         default:  w_state_n = LSU_IDLE;
      endcase
   end

   lsu_load_align u_load_align (
      .i_off    (r_op.off),
      .i_funct3 (r_op.funct3),
      .i_rdata  (mem_rdata),
      .o_data   (w_load_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= LSU_IDLE;
         r_op        <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_rdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state   <= w_state_n;
         r_busy    <= (w_state_n != LSU_IDLE);
         r_done    <= (w_state_n == LSU_DONE);
         r_mem_req <= (w_state_n == LSU_REQ);
         r_mem_we  <= (w_state_n == LSU_REQ) && w_is_store_n;
         if (w_accept) begin
            r_op        <= '{is_store: is_store, funct3: funct3, off: addr[1:0]};
            r_mem_addr  <= {addr[WIDTH-1:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
         end
         if ((r_state == LSU_REQ) && mem_ack && !r_op.is_store)
            r_rdata <= w_load_data;
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_fault <= 1'b0;
      else       r_fault <= w_trap;
   end
`endif

   assign busy      = r_busy;
   assign done      = r_done;
   assign rdata     = r_rdata;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (both LSU_MISALIGN_TRAP_EN builds).
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, is_store;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        busy, done, fault, mem_req, mem_we, mem_ack;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_rdata = 32'h0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store),
      .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy),
      .done(done), .rdata(rdata), .fault(fault), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // Pulses start for one edge; returns at the falling edge of cycle 1.
   task automatic issue(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
      addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      checks++; if ({busy, done, fault, mem_req, mem_we} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got=%b want=00000", {busy, done, fault, mem_req, mem_we}); end
      checks++; if ({mem_addr, mem_wdata, rdata} !== 96'h0) begin
         errors++; $display("FAIL reset_data got=%h %h %h want=0", mem_addr, mem_wdata, rdata); end
      checks++; if (mem_be !== 4'b0) begin
         errors++; $display("FAIL reset_be got=%b want=0000", mem_be); end
      reset = 1'b0;
   endtask

   task automatic test_store;
      issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
      checks++; if ({mem_req, mem_we, busy, done} !== 4'b1110) begin
         errors++; $display("FAIL sb_ctrl got=%b want=1110", {mem_req, mem_we, busy, done}); end
      checks++; if (mem_addr !== 32'h0000_1000) begin
         errors++; $display("FAIL sb_addr got=%h want=00001000", mem_addr); end
      checks++; if (mem_be !== 4'b1000) begin
         errors++; $display("FAIL sb_be got=%b want=1000", mem_be); end
      checks++; if (mem_wdata !== 32'hA5A5_A5A5) begin
         errors++; $display("FAIL sb_wdata got=%h want=a5a5a5a5", mem_wdata); end
      mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      checks++; if ({done, mem_req, mem_we, fault} !== 4'b1000) begin
         errors++; $display("FAIL sb_done got=%b want=1000", {done, mem_req, mem_we, fault}); end
      checks++; if (rdata !== exp_rdata) begin
         errors++; $display("FAIL sb_rdata_kept got=%h want=%h", rdata, exp_rdata); end
      @(negedge clk);
      checks++; if ({done, busy} !== 2'b00) begin
         errors++; $display("FAIL sb_idle got=%b want=00", {done, busy}); end
      // Halfword store into the upper lanes
      issue(1'b1, 3'b001, 32'h0000_6002, 32'h1234_BEEF);
      checks++; if ({mem_be, mem_wdata} !== {4'b1100, 32'hBEEF_BEEF}) begin
         errors++; $display("FAIL sh_lanes got=%b %h want=1100 beefbeef", mem_be, mem_wdata); end
      mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_load_byte;
      mem_rdata = 32'h1234_80FF;
      issue(1'b0, 3'b000, 32'h0000_2001, 32'h0);
      checks++; if ({mem_req, mem_we, mem_be} !== 6'b10_0010) begin
         errors++; $display("FAIL lb_bus got=%b want=100010", {mem_req, mem_we, mem_be}); end
      mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      exp_rdata = 32'hFFFF_FF80;
      checks++; if ({done, rdata} !== {1'b1, exp_rdata}) begin
         errors++; $display("FAIL lb_rdata got=%b %h want=1 %h", done, rdata, exp_rdata); end
      @(negedge clk);
      issue(1'b0, 3'b100, 32'h0000_2001, 32'h0);
      mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      exp_rdata = 32'h0000_0080;
      checks++; if ({done, rdata} !== {1'b1, exp_rdata}) begin
         errors++; $display("FAIL lbu_rdata got=%b %h want=1 %h", done, rdata, exp_rdata); end
      @(negedge clk);
   endtask

   task automatic test_load_half;
      mem_rdata = 32'h8001_0000;
      issue(1'b0, 3'b001, 32'h0000_2002, 32'h0);
      checks++; if (mem_be !== 4'b1100) begin
         errors++; $display("FAIL lh_be got=%b want=1100", mem_be); end
      mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      exp_rdata = 32'hFFFF_8001;
      checks++; if (rdata !== exp_rdata) begin
         errors++; $display("FAIL lh_rdata got=%h want=%h", rdata, exp_rdata); end
      @(negedge clk);
   endtask

   task automatic test_wait_states;
      mem_rdata = 32'hDEAD_BEEF;
      issue(1'b0, 3'b010, 32'h0000_4008, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checks++; if ({mem_req, mem_we, done, mem_addr, mem_be} !== {3'b100, 32'h0000_4008, 4'b1111}) begin
            errors++; $display("FAIL wait_stable_%0d got=%b %h %b", i, {mem_req, mem_we, done}, mem_addr, mem_be); end
         start = (i == 1); is_store = 1'b1; addr = 32'h0000_9000;
         mem_ack = (i == 3);
         @(negedge clk);
      end
      start = 1'b0; mem_ack = 1'b0;
      exp_rdata = 32'hDEAD_BEEF;
      checks++; if ({done, mem_req, rdata} !== {2'b10, exp_rdata}) begin
         errors++; $display("FAIL wait_done got=%b %h want=10 %h", {done, mem_req}, rdata, exp_rdata); end
      // start during DONE must be dropped as well
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      checks++; if ({done, busy, mem_req} !== 3'b000) begin
         errors++; $display("FAIL done_start_ignored got=%b want=000", {done, busy, mem_req}); end
      @(negedge clk);
      checks++; if ({done, busy, mem_req} !== 3'b000) begin
         errors++; $display("FAIL no_second_access got=%b want=000", {done, busy, mem_req}); end
   endtask

   task automatic test_misaligned;
      mem_rdata = 32'hCAFE_F00D;
      issue(1'b0, 3'b010, 32'h0000_3002, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      checks++; if ({mem_req, done, fault, rdata} !== {3'b011, exp_rdata}) begin
         errors++; $display("FAIL misalign_trap got=%b %h want=011 %h", {mem_req, done, fault}, rdata, exp_rdata); end
      @(negedge clk);
      checks++; if ({mem_req, done, fault, busy} !== 4'b0000) begin
         errors++; $display("FAIL misalign_after got=%b want=0000", {mem_req, done, fault, busy}); end
`else
      checks++; if ({mem_req, mem_addr, mem_be, fault} !== {1'b1, 32'h0000_3000, 4'b1111, 1'b0}) begin
         errors++; $display("FAIL misalign_bus got=%b %h %b %b", mem_req, mem_addr, mem_be, fault); end
      mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      exp_rdata = 32'hCAFE_F00D;
      checks++; if ({done, fault, rdata} !== {2'b10, exp_rdata}) begin
         errors++; $display("FAIL misalign_load got=%b %h want=10 %h", {done, fault}, rdata, exp_rdata); end
      @(negedge clk);
`endif
   endtask

   task automatic test_reset_mid_req;
      issue(1'b1, 3'b010, 32'h0000_5004, 32'hAAAA_5555);
      checks++; if (mem_req !== 1'b1) begin
         errors++; $display("FAIL rst_pre_req got=%b want=1", mem_req); end
      #1 reset = 1'b1;
      #1;
      checks++; if ({mem_req, busy, done, mem_we} !== 4'b0000) begin
         errors++; $display("FAIL rst_mid_req got=%b want=0000", {mem_req, busy, done, mem_we}); end
      @(negedge clk); reset = 1'b0;
      exp_rdata = 32'h0;
      issue(1'b1, 3'b010, 32'h0000_5008, 32'h1122_3344);
      checks++; if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== {2'b11, 32'h0000_5008, 4'b1111, 32'h1122_3344}) begin
         errors++; $display("FAIL rst_sw_bus got=%b %h %b %h", {mem_req, mem_we}, mem_addr, mem_be, mem_wdata); end
      mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0;
      checks++; if ({done, rdata} !== {1'b1, exp_rdata}) begin
         errors++; $display("FAIL rst_sw_done got=%b %h want=1 %h", done, rdata, exp_rdata); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_store();
      test_load_byte();
      test_load_half();
      test_wait_states();
      test_misaligned();
      test_reset_mid_req();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
